// File: rtl/riscv_wb_arbiter_if.sv
// Writeback arbiter bus: EX/MEM request handshakes plus the registered
// regfile write port. The forwarding signals are present only when
// RISCV_WB_ARB_FWD_EN is defined.
interface riscv_wb_arbiter_if #(
  parameter int XLEN = 32,
  parameter int REGA = 5
);
  logic            stall;
  logic            ex_valid;
  logic            ex_ready;
  logic [REGA-1:0] ex_rd;
  logic [XLEN-1:0] ex_data;
  logic            mem_valid;
  logic            mem_ready;
  logic [REGA-1:0] mem_rd;
  logic [XLEN-1:0] mem_data;
  logic            wr_en;
  logic [REGA-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            write_on_zero;
`ifdef RISCV_WB_ARB_FWD_EN
  logic [REGA-1:0] fwd_rs;
  logic            fwd_hit;
  logic [XLEN-1:0] fwd_data;

  modport master (
    output stall, ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, fwd_rs,
    input  ex_ready, mem_ready, wr_en, wr_addr, wr_data, write_on_zero, fwd_hit, fwd_data
  );
  modport slave (
    input  stall, ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data, fwd_rs,
    output ex_ready, mem_ready, wr_en, wr_addr, wr_data, write_on_zero, fwd_hit, fwd_data
  );
`else
  modport master (
    output stall, ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    input  ex_ready, mem_ready, wr_en, wr_addr, wr_data, write_on_zero
  );
  modport slave (
    input  stall, ex_valid, ex_rd, ex_data, mem_valid, mem_rd, mem_data,
    output ex_ready, mem_ready, wr_en, wr_addr, wr_data, write_on_zero
  );
`endif
endinterface

// File: rtl/riscv_wb_arbiter.sv
// riscv_wb_arbiter: round-robin share of the single regfile write port
// between EX (ALU results) and MEM (load data). The accepted result is
// registered and presented as a one-cycle write strobe; writes to x0 are
// dropped and flagged on write_on_zero.
// Optional feature: define RISCV_WB_ARB_FWD_EN to add the fwd_rs/fwd_hit/
// fwd_data lookup against the live output register.
module riscv_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int REGN = 32,
  parameter int REGA = $clog2(REGN)
) (
  input logic              clk,
  input logic              rst,
  riscv_wb_arbiter_if.slave bus
);

  typedef enum logic {
    GNT_EX  = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  grant_e          last_grant;
  logic            ex_ready;
  logic            mem_ready;
  logic            wr_en;
  logic [REGA-1:0] wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            write_on_zero;

  // Grant selection: a lone requester wins, a conflict goes to whoever was not served last.
  always_comb begin
    ex_ready  = 1'b0;
    mem_ready = 1'b0;
    if (!bus.stall) begin
      if (bus.ex_valid && bus.mem_valid) begin
        if (last_grant == GNT_MEM) ex_ready  = 1'b1;
        else                       mem_ready = 1'b1;
      end else begin
        ex_ready  = bus.ex_valid;
        mem_ready = bus.mem_valid;
      end
    end
  end

  // Output register: capture the accepted result; x0 targets raise the flag instead of the strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant    <= GNT_MEM;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      write_on_zero <= 1'b0;
    end else begin
      wr_en         <= 1'b0;
      write_on_zero <= 1'b0;
      if (ex_ready) begin
        last_grant <= GNT_EX;
        if (bus.ex_rd == '0) begin
          write_on_zero <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= bus.ex_rd;
          wr_data <= bus.ex_data;
        end
      end else if (mem_ready) begin
        last_grant <= GNT_MEM;
        if (bus.mem_rd == '0) begin
          write_on_zero <= 1'b1;
        end else begin
          wr_en   <= 1'b1;
          wr_addr <= bus.mem_rd;
          wr_data <= bus.mem_data;
        end
      end
    end
  end

  assign bus.ex_ready      = ex_ready;
  assign bus.mem_ready     = mem_ready;
  assign bus.wr_en         = wr_en;
  assign bus.wr_addr       = wr_addr;
  assign bus.wr_data       = wr_data;
  assign bus.write_on_zero = write_on_zero;

`ifdef RISCV_WB_ARB_FWD_EN
  logic fwd_hit;

  // Forward lookup straight off the output register; data is zeroed on a miss.
  always_comb begin
    fwd_hit = wr_en && (wr_addr == bus.fwd_rs) && (bus.fwd_rs != '0);
  end

  assign bus.fwd_hit  = fwd_hit;
  assign bus.fwd_data = fwd_hit ? wr_data : '0;
`endif

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Self-checking bench for riscv_wb_arbiter: a reference model predicts the
// grant and the registered write, pushes it to a scoreboard queue when the
// request is driven, and pops/compares it after the clock edge.
module tb_riscv_wb_arbiter;
  localparam int XLEN = 32;
  localparam int REGA = 5;

  typedef struct {
    logic            en;
    logic [REGA-1:0] addr;
    logic [XLEN-1:0] data;
    logic            woz;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  riscv_wb_arbiter_if #(.XLEN(XLEN), .REGA(REGA)) bus ();

  riscv_wb_arbiter #(.XLEN(XLEN), .REGN(32)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t            sb[$];
  int              checks = 0;
  int              errors = 0;
  logic            m_last;    // 1 = MEM served last
  logic [REGA-1:0] m_addr;
  logic [XLEN-1:0] m_data;
  logic            m_xe;
  logic            m_xm;
  logic [REGA-1:0] obs_addr;

  task automatic idle_inputs();
    bus.stall     = 1'b0;
    bus.ex_valid  = 1'b0;
    bus.ex_rd     = '0;
    bus.ex_data   = '0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = '0;
    bus.mem_data  = '0;
`ifdef RISCV_WB_ARB_FWD_EN
    bus.fwd_rs    = '0;
`endif
  endtask

  task automatic model_reset();
    sb.delete();
    m_last = 1'b1;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One cycle: predict/compare readies, push expected write, clock, pop/compare.
  task automatic step(input string tag);
    exp_t e;
    #1;
    m_xe = !bus.stall && bus.ex_valid  && (!bus.mem_valid || m_last);
    m_xm = !bus.stall && bus.mem_valid && (!bus.ex_valid  || !m_last);
    checks += 2;
    if (bus.ex_ready !== m_xe) begin
      errors++;
      $display("FAIL %s ex_ready got %b expected %b", tag, bus.ex_ready, m_xe);
    end
    if (bus.mem_ready !== m_xm) begin
      errors++;
      $display("FAIL %s mem_ready got %b expected %b", tag, bus.mem_ready, m_xm);
    end
    e.en = 1'b0; e.woz = 1'b0; e.addr = m_addr; e.data = m_data;
    if (m_xe) begin
      m_last = 1'b0;
      if (bus.ex_rd != '0) begin e.en = 1'b1; e.addr = bus.ex_rd; e.data = bus.ex_data; end
      else e.woz = 1'b1;
    end else if (m_xm) begin
      m_last = 1'b1;
      if (bus.mem_rd != '0) begin e.en = 1'b1; e.addr = bus.mem_rd; e.data = bus.mem_data; end
      else e.woz = 1'b1;
    end
    m_addr = e.addr;
    m_data = e.data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    obs_addr = bus.wr_addr;
    checks += 2;
    if (bus.wr_en !== e.en) begin
      errors++;
      $display("FAIL %s wr_en got %b expected %b", tag, bus.wr_en, e.en);
    end
    if (bus.write_on_zero !== e.woz) begin
      errors++;
      $display("FAIL %s write_on_zero got %b expected %b", tag, bus.write_on_zero, e.woz);
    end
    if (e.en) begin
      checks += 2;
      if (bus.wr_addr !== e.addr) begin
        errors++;
        $display("FAIL %s wr_addr got %0d expected %0d", tag, bus.wr_addr, e.addr);
      end
      if (bus.wr_data !== e.data) begin
        errors++;
        $display("FAIL %s wr_data got %h expected %h", tag, bus.wr_data, e.data);
      end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #3;
    checks += 4;
    if (bus.wr_en !== 1'b0)         begin errors++; $display("FAIL reset wr_en got %b expected 0", bus.wr_en); end
    if (bus.wr_addr !== '0)         begin errors++; $display("FAIL reset wr_addr got %0d expected 0", bus.wr_addr); end
    if (bus.wr_data !== '0)         begin errors++; $display("FAIL reset wr_data got %h expected 0", bus.wr_data); end
    if (bus.write_on_zero !== 1'b0) begin errors++; $display("FAIL reset write_on_zero got %b expected 0", bus.write_on_zero); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("reset_idle");
  endtask

  task automatic test_single_ex();
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd5; bus.ex_data = 32'hDEAD_BEEF;
    step("single_ex");
    idle_inputs();
    step("single_ex_after");
  endtask

  task automatic test_conflict();
    logic [REGA-1:0] want [4];
    want[0] = 5'd1; want[1] = 5'd2; want[2] = 5'd1; want[3] = 5'd2;
    do_reset();
    bus.ex_valid  = 1'b1; bus.ex_rd  = 5'd1; bus.ex_data  = 32'h1111_0000;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd2; bus.mem_data = 32'h2222_0000;
    for (int i = 0; i < 4; i++) begin
      step("conflict");
      checks++;
      if (obs_addr !== want[i]) begin
        errors++;
        $display("FAIL conflict_seq[%0d] wr_addr got %0d expected %0d", i, obs_addr, want[i]);
      end
    end
    idle_inputs();
    step("conflict_drain");
  endtask

  task automatic test_x0();
    do_reset();
    bus.mem_valid = 1'b1; bus.mem_rd = '0; bus.mem_data = 32'd7;
    step("x0");
    idle_inputs();
    step("x0_after");
  endtask

  task automatic test_stall();
    do_reset();
    bus.stall     = 1'b1;
    bus.ex_valid  = 1'b1; bus.ex_rd  = 5'd3; bus.ex_data  = 32'h0000_0033;
    bus.mem_valid = 1'b1; bus.mem_rd = 5'd4; bus.mem_data = 32'h0000_0044;
    for (int i = 0; i < 3; i++) step("stall");
    bus.stall = 1'b0;
    step("stall_release");
    checks++;
    if (m_xe !== 1'b1 || obs_addr !== 5'd3) begin
      errors++;
      $display("FAIL stall_first_grant wr_addr got %0d expected 3", obs_addr);
    end
    idle_inputs();
    step("stall_drain");
  endtask

  task automatic test_rst_mid();
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd12; bus.ex_data = 32'hCAFE_0012;
    step("rst_mid_pre");
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid wr_en got %b expected 0", bus.wr_en);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) step("rst_mid_idle");
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 60; i++) begin
      if (!(bus.ex_valid && !m_xe) || i == 0) begin
        bus.ex_valid = 1'($urandom_range(0, 1));
        bus.ex_rd    = REGA'($urandom_range(0, 31));
        bus.ex_data  = $urandom;
      end
      if (!(bus.mem_valid && !m_xm) || i == 0) begin
        bus.mem_valid = 1'($urandom_range(0, 1));
        bus.mem_rd    = REGA'($urandom_range(0, 31));
        bus.mem_data  = $urandom;
      end
      bus.stall = ($urandom_range(0, 5) == 0);
      step("random");
    end
    idle_inputs();
    step("random_drain");
  endtask

`ifdef RISCV_WB_ARB_FWD_EN
  task automatic test_fwd();
    do_reset();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd9; bus.ex_data = 32'h0000_1234;
    step("fwd_xfer");
    idle_inputs();
    bus.fwd_rs = 5'd9;
    #1;
    checks += 2;
    if (bus.fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit got %b expected 1", bus.fwd_hit); end
    if (bus.fwd_data !== 32'h0000_1234) begin errors++; $display("FAIL fwd_data got %h expected 00001234", bus.fwd_data); end
    bus.fwd_rs = '0;
    #1;
    checks += 2;
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_x0_hit got %b expected 0", bus.fwd_hit); end
    if (bus.fwd_data !== '0) begin errors++; $display("FAIL fwd_x0_data got %h expected 0", bus.fwd_data); end
    step("fwd_idle");
    bus.fwd_rs = 5'd9;
    #1;
    checks++;
    if (bus.fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_stale_hit got %b expected 0", bus.fwd_hit); end
    bus.fwd_rs = '0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_ex();
    test_conflict();
    test_x0();
    test_stall();
    test_rst_mid();
`ifdef RISCV_WB_ARB_FWD_EN
    test_fwd();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
